// File: rtl/model_buffer_streamer.sv
// model_buffer_streamer
//
// Holds one model's vertex and index data, which the model loader appends
// once. The transform pipeline then reads the data back in write order. The
// vertex and index channels are independent. Each channel has a write-count
// RAM and a two-state read FSM. A read accepted on one edge gives data, a
// dv pulse and a last flag after the next edge.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   i_clear              pulse: empty both stores and rewind both streams
//   i_rewind             pulse: rewind both read pointers, keep contents
//   i_vertex_wr_en/data  append one vertex {z,y,x} (element [0] is x)
//   i_index_wr_en/data   append one triangle (three vertex indices)
//   i_vertex_read_en     request the next vertex
//   o_vertex, _dv, _last vertex data, valid pulse, final-element flag
//   i_index_read_en      request the next triangle
//   o_index_data,_dv,_last  triangle data, valid pulse, final-element flag
//   o_vertex_count       number of vertices stored
//   o_index_count        number of triangles stored
//   o_overflow           sticky: a write was dropped because its store was full

module model_buffer_streamer #(
    parameter int DATAWIDTH          = 24,
    parameter int MAX_VERTEX_COUNT   = 4096,
    parameter int MAX_TRIANGLE_COUNT = 4096,
    localparam int IW = $clog2(MAX_VERTEX_COUNT),
    localparam int TW = $clog2(MAX_TRIANGLE_COUNT)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_clear,
    input  logic                          i_rewind,
    input  logic                          i_vertex_wr_en,
    input  logic [2:0][DATAWIDTH-1:0]     i_vertex_wr_data,
    input  logic                          i_index_wr_en,
    input  logic [2:0][IW-1:0]            i_index_wr_data,
    input  logic                          i_vertex_read_en,
    output logic [2:0][DATAWIDTH-1:0]     o_vertex,
    output logic                          o_vertex_dv,
    output logic                          o_vertex_last,
    input  logic                          i_index_read_en,
    output logic [2:0][IW-1:0]            o_index_data,
    output logic                          o_index_dv,
    output logic                          o_index_last,
    output logic [IW:0]                   o_vertex_count,
    output logic [TW:0]                   o_index_count,
    output logic                          o_overflow
);

    typedef enum logic {
        RD_READY,
        RD_EXHAUSTED
    } rd_state_t;

    localparam logic [IW:0] V_DEPTH = (IW+1)'(MAX_VERTEX_COUNT);
    localparam logic [TW:0] T_DEPTH = (TW+1)'(MAX_TRIANGLE_COUNT);
    localparam logic [IW:0] V_ONE   = (IW+1)'(1);
    localparam logic [TW:0] T_ONE   = (TW+1)'(1);

    // Storage. The RAMs are deliberately left out of reset.
    logic [2:0][DATAWIDTH-1:0] v_ram [MAX_VERTEX_COUNT];
    logic [2:0][IW-1:0]        t_ram [MAX_TRIANGLE_COUNT];

    // Channel state
    rd_state_t   v_state, t_state;
    logic [IW:0] v_count, v_rptr;
    logic [TW:0] t_count, t_rptr;

    // Per-cycle decisions
    logic        v_fire, v_is_last, v_wr_ok, v_wr_drop;
    logic        t_fire, t_is_last, t_wr_ok, t_wr_drop;
    logic [IW:0] v_rptr_inc;
    logic [TW:0] t_rptr_inc;

    assign v_rptr_inc = v_rptr + V_ONE;
    assign t_rptr_inc = t_rptr + T_ONE;

    // A read is accepted only in READY when data is available. The check uses
    // the count from before any same-cycle write, so a read never sees a
    // write that lands on the same edge. Clear and rewind both kill the read.
    assign v_fire    = !i_clear && !i_rewind && i_vertex_read_en &&
                       (v_state == RD_READY) && (v_rptr < v_count);
    assign t_fire    = !i_clear && !i_rewind && i_index_read_en &&
                       (t_state == RD_READY) && (t_rptr < t_count);
    assign v_is_last = (v_rptr_inc == v_count);
    assign t_is_last = (t_rptr_inc == t_count);

    // A write to a full store is dropped. Clear takes priority over the write.
    assign v_wr_ok   = !i_clear && i_vertex_wr_en && (v_count < V_DEPTH);
    assign v_wr_drop = !i_clear && i_vertex_wr_en && (v_count >= V_DEPTH);
    assign t_wr_ok   = !i_clear && i_index_wr_en && (t_count < T_DEPTH);
    assign t_wr_drop = !i_clear && i_index_wr_en && (t_count >= T_DEPTH);

    // RAM write ports: each write is appended at the current count.
    always_ff @(posedge clk) begin
        if (v_wr_ok) begin
            v_ram[v_count[IW-1:0]] <= i_vertex_wr_data;
        end
        if (t_wr_ok) begin
            t_ram[t_count[TW-1:0]] <= i_index_wr_data;
        end
    end

    // Vertex channel: the write count, plus a read FSM whose dv, last and
    // data outputs are registered. Data keeps its value while dv is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_state       <= RD_READY;
            v_rptr        <= '0;
            v_count       <= '0;
            o_vertex_dv   <= 1'b0;
            o_vertex_last <= 1'b0;
            o_vertex      <= '0;
        end else if (i_clear) begin
            v_state       <= RD_READY;
            v_rptr        <= '0;
            v_count       <= '0;
            o_vertex_dv   <= 1'b0;
            o_vertex_last <= 1'b0;
        end else begin
            if (v_wr_ok) begin
                v_count <= v_count + V_ONE;
            end
            o_vertex_dv   <= v_fire;
            o_vertex_last <= v_fire && v_is_last;
            if (i_rewind) begin
                v_state <= RD_READY;
                v_rptr  <= '0;
            end else if (v_fire) begin
                o_vertex <= v_ram[v_rptr[IW-1:0]];
                v_rptr   <= v_rptr_inc;
                if (v_is_last) begin
                    v_state <= RD_EXHAUSTED;
                end
            end
        end
    end

    // Index channel: same structure as the vertex channel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_state      <= RD_READY;
            t_rptr       <= '0;
            t_count      <= '0;
            o_index_dv   <= 1'b0;
            o_index_last <= 1'b0;
            o_index_data <= '0;
        end else if (i_clear) begin
            t_state      <= RD_READY;
            t_rptr       <= '0;
            t_count      <= '0;
            o_index_dv   <= 1'b0;
            o_index_last <= 1'b0;
        end else begin
            if (t_wr_ok) begin
                t_count <= t_count + T_ONE;
            end
            o_index_dv   <= t_fire;
            o_index_last <= t_fire && t_is_last;
            if (i_rewind) begin
                t_state <= RD_READY;
                t_rptr  <= '0;
            end else if (t_fire) begin
                o_index_data <= t_ram[t_rptr[TW-1:0]];
                t_rptr       <= t_rptr_inc;
                if (t_is_last) begin
                    t_state <= RD_EXHAUSTED;
                end
            end
        end
    end

    // Sticky overflow flag. A dropped write on either channel sets it, and
    // only clear or reset can lower it again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            o_overflow <= 1'b0;
        end else if (v_wr_drop || t_wr_drop) begin
            o_overflow <= 1'b1;
        end
    end

    assign o_vertex_count = v_count;
    assign o_index_count  = t_count;

endmodule

// File: tb/tb_model_buffer_streamer.sv
// tb_model_buffer_streamer
//
// Directed and random stimulus for model_buffer_streamer. The expected
// outputs come from a queue-based reference model that follows the
// behaviour of the block. Every output is compared one time unit after
// each rising clock edge.

module tb_model_buffer_streamer;

    localparam int DW     = 24;
    localparam int NV     = 4096;
    localparam int NT     = 4096;
    localparam int IW     = $clog2(NV);
    localparam int TW     = $clog2(NT);
    localparam int VBITS  = 3 * DW;
    localparam int TBITS  = 3 * IW;

    logic                  clk;
    logic                  rstn;
    logic                  i_clear;
    logic                  i_rewind;
    logic                  i_vertex_wr_en;
    logic [2:0][DW-1:0]    i_vertex_wr_data;
    logic                  i_index_wr_en;
    logic [2:0][IW-1:0]    i_index_wr_data;
    logic                  i_vertex_read_en;
    logic [2:0][DW-1:0]    o_vertex;
    logic                  o_vertex_dv;
    logic                  o_vertex_last;
    logic                  i_index_read_en;
    logic [2:0][IW-1:0]    o_index_data;
    logic                  o_index_dv;
    logic                  o_index_last;
    logic [IW:0]           o_vertex_count;
    logic [TW:0]           o_index_count;
    logic                  o_overflow;

    model_buffer_streamer #(
        .DATAWIDTH         (DW),
        .MAX_VERTEX_COUNT  (NV),
        .MAX_TRIANGLE_COUNT(NT)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_clear         (i_clear),
        .i_rewind        (i_rewind),
        .i_vertex_wr_en  (i_vertex_wr_en),
        .i_vertex_wr_data(i_vertex_wr_data),
        .i_index_wr_en   (i_index_wr_en),
        .i_index_wr_data (i_index_wr_data),
        .i_vertex_read_en(i_vertex_read_en),
        .o_vertex        (o_vertex),
        .o_vertex_dv     (o_vertex_dv),
        .o_vertex_last   (o_vertex_last),
        .i_index_read_en (i_index_read_en),
        .o_index_data    (o_index_data),
        .o_index_dv      (o_index_dv),
        .o_index_last    (o_index_last),
        .o_vertex_count  (o_vertex_count),
        .o_index_count   (o_index_count),
        .o_overflow      (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: stored items, a stream cursor and an end-of-stream flag per channel
    logic [VBITS-1:0] m_vq[$];
    logic [TBITS-1:0] m_tq[$];
    int               m_vnext, m_tnext;
    bit               m_vdone, m_tdone;
    logic [VBITS-1:0] e_vdata;
    logic [TBITS-1:0] e_tdata;
    bit               e_vdv, e_vlast, e_tdv, e_tlast, e_ovf;

    function automatic logic [VBITS-1:0] q13Vertex(input int k);
        logic [DW-1:0] c;
        c = DW'(k * 32'h2000);
        return {c, c, c};
    endfunction

    function automatic logic [VBITS-1:0] randVertex();
        return VBITS'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [TBITS-1:0] tri3(input int a, input int b, input int c);
        return {IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic logic [TBITS-1:0] randTri();
        return TBITS'({$urandom(), $urandom()});
    endfunction

    task automatic modelReset();
        m_vq.delete();
        m_tq.delete();
        m_vnext = 0; m_tnext = 0;
        m_vdone = 0; m_tdone = 0;
        e_vdata = '0; e_tdata = '0;
        e_vdv = 0; e_vlast = 0; e_tdv = 0; e_tlast = 0; e_ovf = 0;
    endtask

    task automatic modelStep(input bit clr, input bit rew,
                             input bit vwr, input logic [VBITS-1:0] vd,
                             input bit twr, input logic [TBITS-1:0] td,
                             input bit vrd, input bit trd);
        int vsz, tsz;
        vsz = m_vq.size();
        tsz = m_tq.size();
        if (clr) begin
            m_vq.delete();
            m_tq.delete();
            m_vnext = 0; m_tnext = 0;
            m_vdone = 0; m_tdone = 0;
            e_vdv = 0; e_vlast = 0; e_tdv = 0; e_tlast = 0; e_ovf = 0;
        end else begin
            e_vdv = 0; e_vlast = 0; e_tdv = 0; e_tlast = 0;
            if (!rew && vrd && !m_vdone && m_vnext < vsz) begin
                e_vdv   = 1;
                e_vdata = m_vq[m_vnext];
                e_vlast = (m_vnext == vsz - 1);
                m_vnext++;
                if (m_vnext == vsz) m_vdone = 1;
            end
            if (!rew && trd && !m_tdone && m_tnext < tsz) begin
                e_tdv   = 1;
                e_tdata = m_tq[m_tnext];
                e_tlast = (m_tnext == tsz - 1);
                m_tnext++;
                if (m_tnext == tsz) m_tdone = 1;
            end
            if (rew) begin
                m_vnext = 0; m_tnext = 0;
                m_vdone = 0; m_tdone = 0;
            end
            if (vwr) begin
                if (vsz < NV) m_vq.push_back(vd);
                else e_ovf = 1;
            end
            if (twr) begin
                if (tsz < NT) m_tq.push_back(td);
                else e_ovf = 1;
            end
        end
    endtask

    task automatic compareField(input string tag, input logic [VBITS-1:0] obs,
                                input logic [VBITS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutput(input string step);
        compareField({step, " vertex_dv"},   VBITS'(o_vertex_dv),    VBITS'(e_vdv));
        compareField({step, " vertex_last"}, VBITS'(o_vertex_last),  VBITS'(e_vlast));
        compareField({step, " vertex"},      VBITS'(o_vertex),       e_vdata);
        compareField({step, " index_dv"},    VBITS'(o_index_dv),     VBITS'(e_tdv));
        compareField({step, " index_last"},  VBITS'(o_index_last),   VBITS'(e_tlast));
        compareField({step, " index_data"},  VBITS'(o_index_data),   VBITS'(e_tdata));
        compareField({step, " vertex_count"}, VBITS'(o_vertex_count), VBITS'(m_vq.size()));
        compareField({step, " index_count"},  VBITS'(o_index_count),  VBITS'(m_tq.size()));
        compareField({step, " overflow"},    VBITS'(o_overflow),     VBITS'(e_ovf));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic applyStimulus(input string step,
                                 input bit clr, input bit rew,
                                 input bit vwr, input logic [VBITS-1:0] vd,
                                 input bit twr, input logic [TBITS-1:0] td,
                                 input bit vrd, input bit trd);
        i_clear          = clr;
        i_rewind         = rew;
        i_vertex_wr_en   = vwr;
        i_vertex_wr_data = vd;
        i_index_wr_en    = twr;
        i_index_wr_data  = td;
        i_vertex_read_en = vrd;
        i_index_read_en  = trd;
        modelStep(clr, rew, vwr, vd, twr, td, vrd, trd);
        @(posedge clk);
        #1;
        checkOutput(step);
    endtask

    task automatic idle(input string step);
        applyStimulus(step, 0, 0, 0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0;
        i_clear = 0; i_rewind = 0;
        i_vertex_wr_en = 0; i_vertex_wr_data = '0;
        i_index_wr_en = 0;  i_index_wr_data = '0;
        i_vertex_read_en = 0; i_index_read_en = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rstn = 1'b1;
        idle("post_reset");

        $display("[TB] three vertices, read held for five cycles");
        for (int k = 1; k <= 3; k++)
            applyStimulus("vwrite", 0, 0, 1, q13Vertex(k), 0, '0, 0, 0);
        for (int k = 0; k < 5; k++)
            applyStimulus("vstream", 0, 0, 0, '0, 0, '0, 1, 0);
        idle("vstream_idle");

        $display("[TB] two triangles, alternate reads, rewind");
        applyStimulus("twrite", 0, 0, 0, '0, 1, tri3(0, 1, 2), 0, 0);
        applyStimulus("twrite", 0, 0, 0, '0, 1, tri3(2, 1, 0), 0, 0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("tread", 0, 0, 0, '0, 0, '0, 0, 1);
            idle("tread_gap");
        end
        applyStimulus("rewind", 0, 1, 0, '0, 0, '0, 0, 0);
        applyStimulus("tread_rw", 0, 0, 0, '0, 0, '0, 0, 1);
        idle("tread_rw_idle");

        $display("[TB] empty store reads, then a single vertex");
        applyStimulus("clear", 1, 0, 0, '0, 0, '0, 0, 0);
        for (int k = 0; k < 4; k++)
            applyStimulus("empty_read", 0, 0, 0, '0, 0, '0, 1, 0);
        applyStimulus("one_write", 0, 0, 1, q13Vertex(5), 0, '0, 0, 0);
        applyStimulus("one_read", 0, 0, 0, '0, 0, '0, 1, 0);
        applyStimulus("one_read_after", 0, 0, 0, '0, 0, '0, 1, 0);

        $display("[TB] fill vertex store, overflow, full stream");
        applyStimulus("clear", 1, 0, 0, '0, 0, '0, 0, 0);
        for (int k = 0; k < NV; k++)
            applyStimulus("fill", 0, 0, 1, randVertex(), 0, '0, 0, 0);
        applyStimulus("overflow", 0, 0, 1, randVertex(), 0, '0, 0, 0);
        for (int k = 0; k < NV + 1; k++)
            applyStimulus("full_stream", 0, 0, 0, '0, 0, '0, 1, 0);
        applyStimulus("clear_full", 1, 0, 0, '0, 0, '0, 0, 0);

        $display("[TB] clear with read, write and pending dv");
        applyStimulus("cw", 0, 0, 1, q13Vertex(1), 0, '0, 0, 0);
        applyStimulus("cw", 0, 0, 1, q13Vertex(2), 0, '0, 0, 0);
        applyStimulus("cr", 0, 0, 0, '0, 0, '0, 1, 0);
        applyStimulus("clear_mix", 1, 0, 1, q13Vertex(7), 1, tri3(1, 1, 1), 1, 1);
        idle("clear_mix_idle");

        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++)
            applyStimulus("random",
                          ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 29) == 0),
                          1'($urandom_range(0, 1)), randVertex(),
                          1'($urandom_range(0, 1)), randTri(),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 2) != 0));

        $display("[TB] async reset mid-stream");
        applyStimulus("clear", 1, 0, 0, '0, 0, '0, 0, 0);
        for (int k = 0; k < 4; k++)
            applyStimulus("prewrite", 0, 0, 1, randVertex(), 1, randTri(), 0, 0);
        applyStimulus("prestream", 0, 0, 0, '0, 0, '0, 1, 1);
        i_vertex_wr_en = 0;
        i_index_wr_en  = 0;
        i_vertex_read_en = 1;
        i_index_read_en  = 1;
        #2;
        rstn = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("async_reset_hold");
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 2; k++)
            applyStimulus("post_rst_read", 0, 0, 0, '0, 0, '0, 1, 1);
        applyStimulus("reload", 0, 0, 1, q13Vertex(3), 1, tri3(4, 5, 6), 0, 0);
        applyStimulus("reload_read", 0, 0, 0, '0, 0, '0, 1, 1);
        idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/model_buffer_streamer.md
# model_buffer_streamer

Dual sequential-access store for one model's vertex and index data. It is loaded once through write ports and then streamed out in order. It is the responder side of the transform pipeline's model-buffer read interface: it answers `vertex_read_en` and `index_read_en` with data, a data-valid strobe and a last flag. It sits between the model loader (writer) and the transform pipeline (reader).

## Interface
Parameters:
- DATAWIDTH, 24, signed vertex component width (Q.13 fixed point; the block only stores it, never interprets it)
- MAX_VERTEX_COUNT, 4096, vertex RAM depth; index width is IW = $clog2(MAX_VERTEX_COUNT)
- MAX_TRIANGLE_COUNT, 4096, index RAM depth (one entry = 3 indices); TW = $clog2(MAX_TRIANGLE_COUNT)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_clear  in  1  pulse: empty both stores, rewind both streams
- i_rewind  in  1  pulse: rewind both read pointers, keep contents
- i_vertex_wr_en  in  1  append one vertex
- i_vertex_wr_data  in  DATAWIDTH x3  signed x,y,z
- i_index_wr_en  in  1  append one triangle
- i_index_wr_data  in  IW x3  vertex indices
- i_vertex_read_en  in  1  request next vertex
- o_vertex  out  DATAWIDTH x3  vertex data
- o_vertex_dv  out  1  o_vertex valid (1-cycle pulse per element)
- o_vertex_last  out  1  qualifies o_vertex_dv; final stored vertex
- i_index_read_en  in  1  request next triangle
- o_index_data  out  IW x3  index triple
- o_index_dv  out  1  o_index_data valid
- o_index_last  out  1  qualifies o_index_dv; final stored triangle
- o_vertex_count  out  IW+1  vertices stored
- o_index_count  out  TW+1  triangles stored
- o_overflow  out  1  sticky: a write was dropped because its store was full

## Operation
- Two independent channels, vertex and index. Each has a synchronous RAM, a write count and a read pointer.
- Write: when wr_en is high and count < depth, store the data at address count and increment count. When count == depth, drop the write and set o_overflow.
- Each channel runs a read FSM:
  - READY: on read_en with rptr < count, issue a RAM read at rptr and increment rptr. If rptr == count-1, go to EXHAUSTED. If count == 0, ignore read_en and stay in READY.
  - EXHAUSTED: ignore read_en and produce no dv.
  - i_rewind or i_clear: go to READY with rptr = 0.
- The last flag is registered alongside dv: o_*_last = 1 exactly when the issued address was count-1.
- Priority, highest first: i_clear > i_rewind > write/read.
  - i_clear drops any same-cycle write or read. It zeroes both counts and o_overflow, and suppresses a dv that is already in flight.
  - i_rewind drops any same-cycle read. Same-cycle writes still occur.
- A read and a write on the same channel in the same cycle are both legal. The read compares against the pre-write count.
- Data outputs hold their last value when dv is low.
- RAM contents are not reset.

## Timing
- Read latency is 1 cycle: read_en accepted at edge N gives dv/last/data valid after edge N+1, for one cycle.
- Back-to-back read_en every cycle gives one element per cycle with no bubbles.
- The write is visible to the read path from the cycle after the wr_en edge.
- Reset (rstn low, asynchronous): both FSMs go to READY, rptr = 0, counts = 0.
  - Outputs: o_vertex_dv = o_index_dv = 0, o_vertex_last = o_index_last = 0, o_overflow = 0, data outputs = 0.
- Reset mid-stream aborts immediately; no dv is emitted after rstn deasserts until a new read_en.
- o_vertex_count and o_index_count are registered and update on the edge after the write.

## Test plan
- Write 3 vertices (1.0, 2.0, 3.0 in Q.13 = 0x2000, 0x4000, 0x6000 per component), then hold vertex_read_en high for 5 cycles -> 3 consecutive dv pulses starting 1 cycle after the first read_en, in write order, last only on the 3rd, and no dv on cycles 4-5.
- Write 2 triangles {0,1,2}, {2,1,0}, then pulse index_read_en on alternate cycles -> 2 dv pulses each 1 cycle after its request, last on {2,1,0}. Then i_rewind followed by read_en -> {0,1,2} again, with last = 0.
- Fill the vertex store to MAX_VERTEX_COUNT, then write once more -> count stays at 4096 and o_overflow = 1. Streaming yields 4096 elements with last on element 4095. i_clear -> count 0, o_overflow 0.
- Empty store with read_en high for 4 cycles -> no dv and no last. Then write 1 vertex and read -> a single dv with last = 1.
- Assert i_clear in the same cycle as a read_en and a wr_en while a dv is pending -> no dv next cycle, count = 0, and the write is dropped.
- Assert rstn low asynchronously mid-stream with read_en held high -> all outputs 0 immediately. After release, the stream restarts at element 0 and requires a reload (count 0).
